// File: rtl/vga_out_stage.sv
// VGA output stage: raster counters, sync generation and LAT-aligned colour registering.
// Optional VGA_TEST_PATTERN_EN adds a test_sel port selecting an eight-bar pattern.
module vga_out_stage #(
  parameter int LAT    = 2,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_sel,
`endif
  input  logic [23:0] pixel_in,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam logic [9:0] H_ACT_W  = 10'(H_ACT);
  localparam logic [9:0] HS_BEG_W = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_END_W = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_W = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_W  = 10'(V_ACT);
  localparam logic [9:0] VS_BEG_W = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_END_W = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_W = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);

  logic [9:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [LAT-1:0] act_sr_q, act_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
  logic [3:0]     vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic           vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
  logic           frame_start_q, frame_start_d;
  logic           h_wrap, v_wrap, raw_act, raw_hs, raw_vs;
  logic [11:0]    dly_rgb;
  logic           pix_unused;

  assign h_wrap  = (h_cnt_q == H_LAST_W);
  assign v_wrap  = (v_cnt_q == V_LAST_W);
  assign raw_act = (h_cnt_q < H_ACT_W) && (v_cnt_q < V_ACT_W);
  assign raw_hs  = !((h_cnt_q >= HS_BEG_W) && (h_cnt_q < HS_END_W));
  assign raw_vs  = !((v_cnt_q >= VS_BEG_W) && (v_cnt_q < VS_END_W));

  // Low nibbles are deliberately dropped: truncation, no rounding.
  assign pix_unused = ^{pixel_in[19:16], pixel_in[11:8], pixel_in[3:0]};

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] hc_sr_q [LAT];
  logic [9:0] hc_sr_d [LAT];
  logic [9:0] bar;
  logic       bar_unused;

  assign bar        = hc_sr_q[LAT-1] / 10'd80;
  assign bar_unused = ^bar[9:3];
  assign dly_rgb    = test_sel ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}}
                               : {pixel_in[23:20], pixel_in[15:12], pixel_in[7:4]};

  always_comb begin
    hc_sr_d = hc_sr_q;
    if (pix_en) begin
      hc_sr_d[0] = h_cnt_q;
      for (int i = 1; i < LAT; i++) hc_sr_d[i] = hc_sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) hc_sr_q[i] <= '0;
    end else begin
      hc_sr_q <= hc_sr_d;
    end
  end
`else
  assign dly_rgb = {pixel_in[23:20], pixel_in[15:12], pixel_in[7:4]};
`endif

  always_comb begin
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    act_sr_d = act_sr_q;
    hs_sr_d  = hs_sr_q;
    vs_sr_d  = vs_sr_q;
    vga_r_d  = vga_r_q;
    vga_g_d  = vga_g_q;
    vga_b_d  = vga_b_q;
    vga_hs_d = vga_hs_q;
    vga_vs_d = vga_vs_q;
    // frame_start is a single-clk pulse, so it is recomputed every clk.
    frame_start_d = pix_en && h_wrap && v_wrap;
    if (pix_en) begin
      h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      if (h_wrap) v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
      act_sr_d[0] = raw_act;
      hs_sr_d[0]  = raw_hs;
      vs_sr_d[0]  = raw_vs;
      for (int i = 1; i < LAT; i++) begin
        act_sr_d[i] = act_sr_q[i-1];
        hs_sr_d[i]  = hs_sr_q[i-1];
        vs_sr_d[i]  = vs_sr_q[i-1];
      end
      vga_r_d  = act_sr_q[LAT-1] ? dly_rgb[11:8] : 4'h0;
      vga_g_d  = act_sr_q[LAT-1] ? dly_rgb[7:4]  : 4'h0;
      vga_b_d  = act_sr_q[LAT-1] ? dly_rgb[3:0]  : 4'h0;
      vga_hs_d = hs_sr_q[LAT-1];
      vga_vs_d = vs_sr_q[LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      act_sr_q      <= '0;
      hs_sr_q       <= '1;
      vs_sr_q       <= '1;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      act_sr_q      <= act_sr_d;
      hs_sr_q       <= hs_sr_d;
      vs_sr_q       <= vs_sr_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hc          = h_cnt_q;
  assign vc          = v_cnt_q;
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// Randomized bench for vga_out_stage on a shrunken raster, checked against a position-count model.
module tb_vga_out_stage;
  localparam int LAT = 2;
  localparam int H_ACT = 40, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACT = 20, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n, pix_en;
  logic [23:0] pixel_in;
  logic [9:0]  hc, vc;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;

  int total = 0;
  int bad   = 0;
  int n     = 0;       // enabled edges since reset release
  bit fs_exp = 1'b0;
  logic [23:0] key;

  always #5 clk = ~clk;

  vga_out_stage #(
    .LAT(LAT), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pixel_in(pixel_in),
    .hc(hc), .vc(vc), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t n=%0d)", tag, obs, exp, $time, n);
    end
  endtask

  function automatic bit is_act(input int p);
    return ((p % HT) < H_ACT) && ((p / HT) < V_ACT);
  endfunction

  function automatic logic [23:0] pix_of(input int p);
    int h, v, s;
    h = p % HT;
    v = p / HT;
    s = h * 3 + v * 7;
    return {h[7:0] ^ key[7:0], v[7:0] ^ key[15:8], s[7:0] ^ key[23:16]};
  endfunction

  task automatic check_all();
    int p, q, h, v;
    logic [23:0] px;
    p = n % FR;
    chk("hc", 32'(hc), 32'(p % HT));
    chk("vc", 32'(vc), 32'(p / HT));
    chk("frame_start", 32'(frame_start), 32'(fs_exp));
    q = n - (LAT + 1);
    if (q < 0) begin
      chk("r", 32'(vga_r), 0); chk("g", 32'(vga_g), 0); chk("b", 32'(vga_b), 0);
      chk("hs", 32'(vga_hs), 1); chk("vs", 32'(vga_vs), 1);
    end else begin
      q = q % FR;
      h = q % HT;
      v = q / HT;
      px = is_act(q) ? pix_of(q) : 24'h0;
      chk("r", 32'(vga_r), 32'(px[23:20]));
      chk("g", 32'(vga_g), 32'(px[15:12]));
      chk("b", 32'(vga_b), 32'(px[7:4]));
      chk("hs", 32'(vga_hs), (h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC) ? 0 : 1);
      chk("vs", 32'(vga_vs), (v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC) ? 0 : 1);
    end
  endtask

  task automatic chk_reset();
    chk("rst_hc", 32'(hc), 0);   chk("rst_vc", 32'(vc), 0);
    chk("rst_r", 32'(vga_r), 0); chk("rst_g", 32'(vga_g), 0); chk("rst_b", 32'(vga_b), 0);
    chk("rst_hs", 32'(vga_hs), 1); chk("rst_vs", 32'(vga_vs), 1);
    chk("rst_fs", 32'(frame_start), 0);
  endtask

  // Drive one clk: pixel_in answers the request presented LAT enabled edges ago.
  task automatic step(input bit en);
    int q;
    pix_en = en;
    q = n - LAT;
    if (en && q >= 0 && is_act(q % FR)) pixel_in = pix_of(q % FR);
    else pixel_in = 24'($urandom);
    @(posedge clk);
    if (en) begin
      n++;
      fs_exp = (n % FR) == 0;
    end else begin
      fs_exp = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic hold_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      pix_en = 1'($urandom);
      pixel_in = 24'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk_reset();
    end
    rst_n = 1'b1;
    n = 0;
    fs_exp = 1'b0;
  endtask

  initial begin
    key = 24'($urandom);
    rst_n = 1'b0;
    pix_en = 1'b0;
    pixel_in = '0;
    hold_reset(3);

    for (int i = 0; i < 3500; i++) step(1'($urandom_range(0, 1)));

    // Walk into the middle of the active area, then reset asynchronously.
    for (int i = 0; i < 20000 && (n % FR) != (10 * HT + 30); i++) step(1'($urandom_range(0, 1)));
    chk("reach_mid", 32'(n % FR), 32'(10 * HT + 30));
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    hold_reset(2);

    for (int i = 0; i < 7000; i++) step(i % 4 == 0);
    for (int i = 0; i < 3200; i++) step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_out_stage.md
VGA_OUT_STAGE -- requirements
Module: vga_out_stage

Interface
REQ-001 Parameter LAT, default 2: pix_en-qualified cycles from hc/vc presentation to pixel_in valid; legal range 1..4.
REQ-002 Parameter H_ACT/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels.
REQ-003 Parameter V_ACT/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pix_en  in  1  pixel-rate strobe; the block advances only on clk edges where pix_en=1.
REQ-007 hc  out  10  requested pixel column, registered.
REQ-008 vc  out  10  requested pixel line, registered.
REQ-009 pixel_in  in  24  {R[23:16],G[15:8],B[7:0]} from the dithering stage for the request issued LAT enabled cycles earlier.
REQ-010 vga_r / vga_g / vga_b  out  4 each  DAC colour, registered.
REQ-011 vga_hs / vga_vs  out  1 each  sync, active-low, registered.
REQ-012 frame_start  out  1  one-clk pulse at the start of each frame.
REQ-013 test_sel  in  1  present only with VGA_TEST_PATTERN_EN; selects the internal pattern.

Function
REQ-014 Horizontal counter 0..H_TOT-1 (H_TOT = 800), +1 per enabled cycle; wraps to 0 at H_TOT-1.
REQ-015 Vertical counter 0..V_TOT-1 (V_TOT = 525), +1 only when the horizontal counter wraps; wraps to 0 at V_TOT-1 together with the horizontal wrap.
REQ-016 hc/vc equal the counters.
REQ-017 Raw active = (hc < H_ACT) && (vc < V_ACT).
REQ-018 Raw hsync low for H_ACT+H_FP <= hc < H_ACT+H_FP+H_SYNC.
REQ-019 Raw vsync low for V_ACT+V_FP <= vc < V_ACT+V_FP+V_SYNC.
REQ-020 Raw active, hsync and vsync pass through a LAT-deep shift register advanced only on pix_en.
REQ-021 On each enabled edge, vga_r/g/b load pixel_in[23:20]/[15:12]/[7:4] when delayed active=1, else 4'h0.
REQ-022 On each enabled edge, vga_hs/vga_vs load delayed hsync/vsync in the same edge as colour.
REQ-023 End-to-end latency: (h,v) on hc/vc appears on the vga_* outputs after LAT+1 enabled edges; sync, colour and blanking stay mutually aligned.
REQ-024 With pix_en=0, all registers hold; no output changes.
REQ-025 frame_start=1 for exactly one clk, on the enabled edge where the counters wrap from (799,524) to (0,0); otherwise 0.
REQ-026 Colour truncation only, no rounding; bits [3:0] of each channel are ignored.

Reset
REQ-027 rst_n=0 asynchronously clears: counters; hc=0, vc=0; delay lines to active=0, hsync=1, vsync=1; vga_r/g/b=0; vga_hs=vga_vs=1; frame_start=0.
REQ-028 Reset mid-frame abandons the frame; after release, the first enabled edge advances hc from 0 to 1; no frame_start for the abandoned frame.
REQ-029 Outputs carry no glitch or partial pulse on rst_n release; the first enabled edge after release produces blanked colour.

Configuration
REQ-030 Macro VGA_TEST_PATTERN_EN defined: port test_sel exists; when test_sel=1, delayed-active colour is eight vertical bars 80 px wide (bar index = delayed hc[9:0]/80), colour {R,G,B} = {idx[2]?F:0, idx[1]?F:0, idx[0]?F:0}, and pixel_in is ignored; test_sel is sampled per enabled edge.
REQ-031 Macro VGA_TEST_PATTERN_EN undefined: no test_sel port and no pattern logic; colour always derives from pixel_in.

Verification
REQ-032 pix_en=1 every clk, reset release -> vga_hs low for exactly 96 enabled cycles per line; line period 800; vsync low for exactly 2 lines (1600 cycles); frame period 420000.
REQ-033 pixel_in = {hc[7:0], vc[7:0], 8'hA5} echoed with LAT=2 -> at hc=(5,7) the output shows vga_r=0, vga_g=0, vga_b=A on the third enabled edge after presentation; during blanking (hc>=640) outputs are 0.
REQ-034 pix_en toggled 1-of-4 cycles -> same output sequence as REQ-032, stretched 4x; outputs constant while pix_en=0.
REQ-035 Run to (799,524), then one enabled edge -> frame_start high for one clk; hc=vc=0.
REQ-036 Assert rst_n at (300,200) mid-active -> immediate vga_*=0, vga_hs=vga_vs=1, hc=vc=0; after release, normal timing restarts from (0,0).
REQ-037 VGA_TEST_PATTERN_EN with test_sel=1 -> columns 0-79 show 000, 80-159 show 00F, and 560-639 show FFF.
